// File: rtl/dma_copy_scheduler_pkg.sv
// Shared constants for the DMA copy scheduler: state encoding, direction codes, default widths.
package dma_sched_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  // Scheduler FSM encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] COPY  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Copy direction codes carried on req_dir
  localparam logic DIR_RAM2HDD = 1'b0;
  localparam logic DIR_HDD2RAM = 1'b1;

endpackage

// File: rtl/dma_copy_scheduler_if.sv
// Request and memory bus bundle between the DMA copy scheduler and its environment.
interface dma_copy_scheduler_if
  import dma_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [1:0]          req;
  logic [1:0]          req_dir;
  logic [2*ADDR_W-1:0] req_ram_pos;
  logic [2*ADDR_W-1:0] req_hdd_pos;
  logic [2*ADDR_W-1:0] req_cells;
  logic [1:0]          ack;
  logic [1:0]          done;
  logic                busy;
  logic                active_id;
  logic [ADDR_W-1:0]   pram_addr;
  logic [DATA_W-1:0]   pram_data;
  logic                pram_wb_flag;
  logic [DATA_W-1:0]   pram_wb_data;
  logic [ADDR_W-1:0]   hdd_addr;
  logic [DATA_W-1:0]   hdd_data;
  logic                hdd_wb_flag;
  logic [DATA_W-1:0]   hdd_wb_data;

  // Scheduler side
  modport slave (
    input  req, req_dir, req_ram_pos, req_hdd_pos, req_cells, pram_data, hdd_data,
    output ack, done, busy, active_id,
    output pram_addr, pram_wb_flag, pram_wb_data, hdd_addr, hdd_wb_flag, hdd_wb_data
  );

  // Requesters and memories side
  modport master (
    output req, req_dir, req_ram_pos, req_hdd_pos, req_cells, pram_data, hdd_data,
    input  ack, done, busy, active_id,
    input  pram_addr, pram_wb_flag, pram_wb_data, hdd_addr, hdd_wb_flag, hdd_wb_data
  );

endinterface

// File: rtl/dma_copy_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; the tie-break pointer moves away from whoever was just served.
module rr_arbiter2
  import dma_sched_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic [1:0] grant
);

  logic prio_reg;  // requester that wins a tie

  // Advance the tie-break pointer when a task finishes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio_reg <= 1'b0;
    end else if (update) begin
      prio_reg <= ~served;
    end
  end

  // A lone request always wins; on a tie the favoured requester wins
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = prio_reg ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dma_copy_scheduler.sv
// Two-requester block-copy scheduler between RAM and HDD with a one-read/one-write pipelined datapath.
module dma_copy_scheduler
  import dma_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic                  clock,
  input logic                  reset,
  dma_copy_scheduler_if.slave  bus
);

  localparam logic [ADDR_W:0] IDX_ONE = 1;

  logic [1:0]        state_reg;
  logic              id_reg;
  logic              dir_reg;
  logic [ADDR_W-1:0] src_base_reg;
  logic [ADDR_W-1:0] dst_base_reg;
  logic [ADDR_W-1:0] cells_reg;
  logic [ADDR_W:0]   rd_idx_reg;   // one bit wider so the compare against 0xFFFF cells never wraps
  logic [ADDR_W:0]   wr_idx_reg;
  logic              wr_pend_reg;  // a source word read last cycle is due to be written now

  logic [1:0]        grant;
  logic              rd_active;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] src_data;

  logic [ADDR_W-1:0] ram_pos_arr [2];
  logic [ADDR_W-1:0] hdd_pos_arr [2];
  logic [ADDR_W-1:0] cells_arr   [2];

  // Unpack the flattened per-requester fields
  for (genvar gi = 0; gi < 2; gi++) begin : g_fields
    assign ram_pos_arr[gi] = bus.req_ram_pos[gi*ADDR_W +: ADDR_W];
    assign hdd_pos_arr[gi] = bus.req_hdd_pos[gi*ADDR_W +: ADDR_W];
    assign cells_arr[gi]   = bus.req_cells[gi*ADDR_W +: ADDR_W];
  end

  rr_arbiter2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    (bus.req),
    .update (state_reg == DONE),
    .served (id_reg),
    .grant  (grant)
  );

  assign rd_active = (state_reg == COPY) && (rd_idx_reg < {1'b0, cells_reg});
  assign rd_addr   = src_base_reg + rd_idx_reg[ADDR_W-1:0];
  assign wr_addr   = dst_base_reg + wr_idx_reg[ADDR_W-1:0];
  assign src_data  = (dir_reg == DIR_RAM2HDD) ? bus.pram_data : bus.hdd_data;

  // Task FSM: pick a winner, capture its fields, stream the copy, report completion
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      id_reg       <= 1'b0;
      dir_reg      <= DIR_RAM2HDD;
      src_base_reg <= '0;
      dst_base_reg <= '0;
      cells_reg    <= '0;
      rd_idx_reg   <= '0;
      wr_idx_reg   <= '0;
      wr_pend_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|bus.req) begin
            id_reg    <= grant[1];
            state_reg <= GRANT;
          end
        end
        GRANT: begin
          dir_reg <= bus.req_dir[id_reg];
          if (bus.req_dir[id_reg] == DIR_RAM2HDD) begin
            src_base_reg <= ram_pos_arr[id_reg];
            dst_base_reg <= hdd_pos_arr[id_reg];
          end else begin
            src_base_reg <= hdd_pos_arr[id_reg];
            dst_base_reg <= ram_pos_arr[id_reg];
          end
          cells_reg   <= cells_arr[id_reg];
          rd_idx_reg  <= '0;
          wr_idx_reg  <= '0;
          wr_pend_reg <= 1'b0;
          state_reg   <= (cells_arr[id_reg] == '0) ? DONE : COPY;
        end
        COPY: begin
          if (rd_active) begin
            rd_idx_reg <= rd_idx_reg + IDX_ONE;
          end
          wr_pend_reg <= rd_active;
          if (wr_pend_reg) begin
            wr_idx_reg <= wr_idx_reg + IDX_ONE;
            if ((wr_idx_reg + IDX_ONE) == {1'b0, cells_reg}) begin
              state_reg <= DONE;
            end
          end
        end
        default: begin
          wr_pend_reg <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack       = (state_reg == GRANT) ? (id_reg ? 2'b10 : 2'b01) : 2'b00;
  assign bus.done      = (state_reg == DONE)  ? (id_reg ? 2'b10 : 2'b01) : 2'b00;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.active_id = id_reg & bus.busy;

  // Route the read and write stages onto the two memories; idle memories see all zeros
  always_comb begin
    bus.pram_addr    = '0;
    bus.pram_wb_flag = 1'b0;
    bus.pram_wb_data = '0;
    bus.hdd_addr     = '0;
    bus.hdd_wb_flag  = 1'b0;
    bus.hdd_wb_data  = '0;
    if (dir_reg == DIR_RAM2HDD) begin
      if (rd_active) bus.pram_addr = rd_addr;
      if (wr_pend_reg) begin
        bus.hdd_addr    = wr_addr;
        bus.hdd_wb_flag = 1'b1;
        bus.hdd_wb_data = src_data;
      end
    end else begin
      if (rd_active) bus.hdd_addr = rd_addr;
      if (wr_pend_reg) begin
        bus.pram_addr    = wr_addr;
        bus.pram_wb_flag = 1'b1;
        bus.pram_wb_data = src_data;
      end
    end
  end

endmodule

// File: tb/tb_dma_copy_scheduler.sv
// Self-checking bench: memory models, copy-level reference model, vector table, corner sequences, random tasks.
module tb_dma_copy_scheduler;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dma_copy_scheduler_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  dma_copy_scheduler #(.ADDR_W(16), .DATA_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  // Memory models: one-cycle read latency, write on clock edge
  logic [31:0] ram_mem [0:65535];
  logic [31:0] hdd_mem [0:65535];
  logic [31:0] ram_ref [0:65535];
  logic [31:0] hdd_ref [0:65535];
  bit mem_ready = 1'b0;
  int ram_wr_cnt = 0;
  int hdd_wr_cnt = 0;

  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 65536; i++) begin
        ram_mem[i] <= $urandom;
        hdd_mem[i] <= $urandom;
      end
      ram_mem[16'h0010] <= 32'h0000_000A;
      ram_mem[16'h0011] <= 32'h0000_000B;
      ram_mem[16'h0012] <= 32'h0000_000C;
      ram_mem[16'h0013] <= 32'h0000_000D;
      mem_ready <= 1'b1;
    end else begin
      bus.pram_data <= ram_mem[bus.pram_addr];
      bus.hdd_data  <= hdd_mem[bus.hdd_addr];
      if (bus.pram_wb_flag) begin
        ram_mem[bus.pram_addr] <= bus.pram_wb_data;
        ram_wr_cnt <= ram_wr_cnt + 1;
      end
      if (bus.hdd_wb_flag) begin
        hdd_mem[bus.hdd_addr] <= bus.hdd_wb_data;
        hdd_wr_cnt <= hdd_wr_cnt + 1;
      end
    end
  end

  typedef struct {
    int          id;
    logic        dir;
    logic [15:0] ram;
    logic [15:0] hdd;
    logic [15:0] cells;
    int          exp_done_lat;
    int          exp_writes;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Copy semantics: destination range receives the source range, addresses wrap at 16 bits
  task automatic model_copy(input logic dir, input logic [15:0] ram, input logic [15:0] hdd,
                            input logic [15:0] cells);
    logic [15:0] ra, ha;
    for (int i = 0; i < int'(cells); i++) begin
      ra = ram + 16'(i);
      ha = hdd + 16'(i);
      if (dir == 1'b0) hdd_ref[ha] = ram_ref[ra];
      else             ram_ref[ra] = hdd_ref[ha];
    end
  endtask

  task automatic mem_compare(input string name);
    int bad = 0;
    for (int i = 0; i < 65536; i++) begin
      if (ram_mem[i] !== ram_ref[i] || hdd_mem[i] !== hdd_ref[i]) bad++;
    end
    check(name, 64'(bad), 64'd0);
  endtask

  task automatic set_fields(input int id, input logic dir, input logic [15:0] ram,
                            input logic [15:0] hdd, input logic [15:0] cells);
    bus.req_dir[id]            = dir;
    bus.req_ram_pos[id*16 +: 16] = ram;
    bus.req_hdd_pos[id*16 +: 16] = hdd;
    bus.req_cells[id*16 +: 16]   = cells;
  endtask

  // Steps at least once, then until an ack is seen or the budget runs out
  task automatic wait_ack(output logic [1:0] a, output int n);
    bit seen = 0;
    n = 0;
    a = 2'b00;
    while (!seen && n < 100) begin
      step();
      n++;
      if (bus.ack != 2'b00) begin
        seen = 1;
        a = bus.ack;
      end
    end
  endtask

  // Checks the current sample first, then steps until done is seen or the budget runs out
  task automatic wait_done(output logic [1:0] d, output int n);
    n = 0;
    while (bus.done == 2'b00 && n < 200) begin
      step();
      n++;
    end
    d = bus.done;
  endtask

  task automatic run_task(input vec_t v);
    logic [1:0] a, d;
    int n, m, r0, h0;
    logic [1:0] exp_oh;
    exp_oh = (v.id == 1) ? 2'b10 : 2'b01;
    r0 = ram_wr_cnt;
    h0 = hdd_wr_cnt;
    set_fields(v.id, v.dir, v.ram, v.hdd, v.cells);
    model_copy(v.dir, v.ram, v.hdd, v.cells);
    bus.req[v.id] = 1'b1;
    wait_ack(a, n);
    check("ack_id", 64'(a), 64'(exp_oh));
    check("ack_lat", 64'(n), 64'd1);
    check("active_id", 64'(bus.active_id), 64'(v.id));
    step();
    bus.req[v.id] = 1'b0;
    wait_done(d, m);
    check("done_id", 64'(d), 64'(exp_oh));
    check("done_lat", 64'(m + 1), 64'(v.exp_done_lat));
    step();
    check("done_once", 64'(bus.done), 64'd0);
    check("busy_low", 64'(bus.busy), 64'd0);
    check("dst_writes", 64'(v.dir ? ram_wr_cnt - r0 : hdd_wr_cnt - h0), 64'(v.exp_writes));
    check("src_writes", 64'(v.dir ? hdd_wr_cnt - h0 : ram_wr_cnt - r0), 64'd0);
    mem_compare("mem_contents");
    $display("task id=%0d dir=%0d ram=%04h hdd=%04h cells=%0d done_lat=%0d", v.id, v.dir,
             v.ram, v.hdd, v.cells, m + 1);
  endtask

  function automatic logic outputs_nonzero();
    return |{bus.ack, bus.done, bus.busy, bus.active_id, bus.pram_addr, bus.pram_wb_flag,
             bus.pram_wb_data, bus.hdd_addr, bus.hdd_wb_flag, bus.hdd_wb_data};
  endfunction

  vec_t table_v [4];

  initial begin
    logic [1:0] a, d;
    int n, m, h0;
    bit early;
    vec_t v;

    bus.req = 2'b00;
    bus.req_dir = 2'b00;
    bus.req_ram_pos = '0;
    bus.req_hdd_pos = '0;
    bus.req_cells = '0;

    table_v[0] = '{id: 0, dir: 1'b0, ram: 16'h0010, hdd: 16'h0200, cells: 16'd4,
                   exp_done_lat: 6, exp_writes: 4};
    table_v[1] = '{id: 1, dir: 1'b0, ram: 16'h0020, hdd: 16'h0210, cells: 16'd0,
                   exp_done_lat: 1, exp_writes: 0};
    table_v[2] = '{id: 0, dir: 1'b1, ram: 16'hFFFF, hdd: 16'hFFFE, cells: 16'd3,
                   exp_done_lat: 5, exp_writes: 3};
    table_v[3] = '{id: 1, dir: 1'b1, ram: 16'h0040, hdd: 16'h0050, cells: 16'd1,
                   exp_done_lat: 3, exp_writes: 1};

    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", 64'(outputs_nonzero()), 64'd0);
    ram_ref = ram_mem;
    hdd_ref = hdd_mem;
    reset = 1'b0;
    step();

    // Vector table
    for (int k = 0; k < 4; k++) begin
      run_task(table_v[k]);
      if (k == 0) begin
        for (int i = 0; i < 4; i++) begin
          check("hdd_ABCD", 64'(hdd_mem[16'h0200 + 16'(i)]), 64'(32'h0000_000A + i));
        end
      end
    end

    // Simultaneous requests: 0 first, then 1, then 0 again while req0 stays high
    set_fields(0, 1'b0, 16'h0100, 16'h0300, 16'd2);
    set_fields(1, 1'b1, 16'h0400, 16'h0500, 16'd3);
    model_copy(1'b0, 16'h0100, 16'h0300, 16'd2);
    model_copy(1'b1, 16'h0400, 16'h0500, 16'd3);
    bus.req = 2'b11;
    wait_ack(a, n);
    check("sim_first", 64'(a), 64'b01);
    wait_done(d, m);
    check("sim_done0", 64'(d), 64'b01);
    wait_ack(a, n);
    check("sim_second", 64'(a), 64'b10);
    step();
    bus.req[1] = 1'b0;
    wait_done(d, m);
    check("sim_done1", 64'(d), 64'b10);
    wait_ack(a, n);
    check("sim_third", 64'(a), 64'b01);
    step();
    bus.req[0] = 1'b0;
    wait_done(d, m);
    check("sim_done2", 64'(d), 64'b01);
    step();
    mem_compare("sim_mem");
    $display("sequence simultaneous requests complete");

    // Request from 1 while 0 is busy
    set_fields(0, 1'b0, 16'h0600, 16'h0700, 16'd6);
    set_fields(1, 1'b1, 16'h0900, 16'h0800, 16'd1);
    model_copy(1'b0, 16'h0600, 16'h0700, 16'd6);
    model_copy(1'b1, 16'h0900, 16'h0800, 16'd1);
    bus.req[0] = 1'b1;
    wait_ack(a, n);
    check("busy_ack0", 64'(a), 64'b01);
    step();
    bus.req[0] = 1'b0;
    step();
    step();
    bus.req[1] = 1'b1;
    early = 0;
    m = 0;
    while (bus.done == 2'b00 && m < 50) begin
      if (bus.ack[1]) early = 1;
      step();
      m++;
    end
    check("no_early_ack1", 64'(early), 64'd0);
    check("busy_done0", 64'(bus.done), 64'b01);
    wait_ack(a, n);
    check("busy_ack1", 64'(a), 64'b10);
    check("busy_ack1_gap", 64'(n), 64'd2);
    step();
    bus.req[1] = 1'b0;
    wait_done(d, m);
    check("busy_done1", 64'(d), 64'b10);
    step();
    mem_compare("busy_mem");
    $display("sequence request during busy complete");

    // Reset two cycles into an 8-cell copy: only the first word has landed
    set_fields(0, 1'b0, 16'h0A00, 16'h0B00, 16'd8);
    h0 = hdd_wr_cnt;
    bus.req[0] = 1'b1;
    wait_ack(a, n);
    check("rst_ack0", 64'(a), 64'b01);
    step();
    bus.req[0] = 1'b0;
    step();
    step();
    check("rst_pre_write", 64'(bus.hdd_wb_flag), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_outputs", 64'(outputs_nonzero()), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    early = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.done != 2'b00 || bus.busy) early = 1;
      step();
    end
    check("rst_no_done", 64'(early), 64'd0);
    check("rst_partial_writes", 64'(hdd_wr_cnt - h0), 64'd1);
    model_copy(1'b0, 16'h0A00, 16'h0B00, 16'd1);
    mem_compare("rst_mem");
    $display("sequence reset mid-copy complete");

    // Randomised tasks against the copy-level model
    for (int k = 0; k < 30; k++) begin
      v.id    = int'($urandom_range(0, 1));
      v.dir   = 1'($urandom_range(0, 1));
      v.ram   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF)) : 16'($urandom);
      v.hdd   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF)) : 16'($urandom);
      v.cells = 16'($urandom_range(0, 24));
      v.exp_done_lat = (v.cells == 0) ? 1 : int'(v.cells) + 2;
      v.exp_writes   = int'(v.cells);
      run_task(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
